// File: rtl/definitions_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : definitions_pkg                                               |
// | Purpose: Shared types for the ALU and the ALU scheduler: opcode enum,  |
// |          instruction word, scheduler FSM states and datapath width.    |
// | Ports  : none (package)                                                |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
package definitions_pkg;

  localparam int ALU_W = 32;

  // Encodings 5..7 are deliberately left undefined; the ALU returns 0 for them.
  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4
  } opcode_e;

  typedef struct packed {
    opcode_e            opcode;
    logic [ALU_W-1:0]   a;
    logic [ALU_W-1:0]   b;
  } instruction_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : alu                                                           |
// | Purpose: Purely combinational 32-bit ALU shared through alu_scheduler. |
// | Ports  : iw     in  instruction_t  {opcode, a, b}                      |
// |          result out ALU_W          operation result (0 if undefined)   |
// |          zero   out 1              result == 0                         |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module alu
  import definitions_pkg::*;
(
  input  instruction_t       iw,
  output logic [ALU_W-1:0]   result,
  output logic               zero
);

  always_comb begin
    result = '0;
    case (iw.opcode)
      OP_ADD:  result = iw.a + iw.b;
      OP_SUB:  result = iw.a - iw.b;
      OP_AND:  result = iw.a & iw.b;
      OP_OR:   result = iw.a | iw.b;
      OP_XOR:  result = iw.a ^ iw.b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : rr_arbiter                                                    |
// | Purpose: Combinational round-robin pick: first asserted request at or  |
// |          after ptr, wrapping N-1 -> 0. Pointer storage is external.    |
// | Ports  : req     in  N      request vector                             |
// |          ptr     in  IDX_W  highest-priority index                     |
// |          gnt     out N      one-hot grant (0 when no request)          |
// |          gnt_idx out IDX_W  index of the granted request               |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module rr_arbiter #(
  parameter  int N     = 4,
  localparam int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  // One extra bit so ptr + offset (< 2N) never overflows before wrapping.
  logic [IDX_W:0]   w_sum;
  logic [IDX_W-1:0] w_idx;
  logic             w_any;

  always_comb begin
    gnt_idx = '0;
    w_any   = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    // Walk offsets from farthest to nearest so the nearest hit wins.
    for (int i = N - 1; i >= 0; i--) begin
      w_sum = {1'b0, ptr} + (IDX_W+1)'(i);
      if (w_sum >= (IDX_W+1)'(N)) begin
        w_sum = w_sum - (IDX_W+1)'(N);
      end
      w_idx = w_sum[IDX_W-1:0];
      if (req[w_idx]) begin
        gnt_idx = w_idx;
        w_any   = 1'b1;
      end
    end
    gnt = w_any ? ({{(N-1){1'b0}}, 1'b1} << gnt_idx) : '0;
  end

endmodule
`default_nettype wire

// File: rtl/alu_scheduler.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module : alu_scheduler                                                 |
// | Purpose: Shares one combinational ALU between NUM_REQ requesters with  |
// |          round-robin arbitration and a tagged valid/ready response.    |
// | Ports  : clk, rst_n (async active-low)                                 |
// |          req_valid/req_ready/req_iw   per-requester request channel    |
// |          alu_iw/alu_result/alu_zero   link to the shared ALU           |
// |          rsp_valid/rsp_ready/rsp_id/rsp_result/rsp_zero  response      |
// | Rev    : 1.0  initial release                                          |
// +------------------------------------------------------------------------+
module alu_scheduler
  import definitions_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_REQ-1:0]                req_valid,
  output logic [NUM_REQ-1:0]                req_ready,
  input  instruction_t [NUM_REQ-1:0]        req_iw,
  output instruction_t                      alu_iw,
  input  logic [ALU_W-1:0]                  alu_result,
  input  logic                              alu_zero,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [ID_W-1:0]                   rsp_id,
  output logic [ALU_W-1:0]                  rsp_result,
  output logic                              rsp_zero
);

  sched_state_e        r_state;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_id_q;

  logic [NUM_REQ-1:0]  w_gnt;
  logic [ID_W-1:0]     w_gnt_idx;
  logic [ID_W-1:0]     w_next_ptr;
  logic                w_any_req;
  logic                w_arb_en;
  logic                w_accept;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (r_rr_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign w_any_req  = |req_valid;
  // rst_n gates the grant so nothing is handshaken while reset is held.
  assign w_arb_en   = rst_n && ((r_state == IDLE) || ((r_state == RESP) && rsp_ready));
  assign w_accept   = w_arb_en && w_any_req;
  assign w_next_ptr = (w_gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + ID_W'(1);

  always_comb begin
    req_ready = '0;
    if (w_arb_en) begin
      req_ready = w_gnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_id_q     <= '0;
      alu_iw     <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
    end else begin
      case (r_state)
        IDLE, RESP: begin
          if (r_state == RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
          end
          if (w_accept) begin
            alu_iw   <= req_iw[w_gnt_idx];
            r_id_q   <= w_gnt_idx;
            r_rr_ptr <= w_next_ptr;
            r_state  <= EXEC;
          end else if (r_state == RESP && rsp_ready) begin
            r_state <= IDLE;
          end
        end
        EXEC: begin
          rsp_result <= alu_result;
          rsp_zero   <= alu_zero;
          rsp_id     <= r_id_q;
          rsp_valid  <= 1'b1;
          r_state    <= RESP;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
